// File: rtl/pid_mixer_defs.sv
// pid_mixer_defs: shared FSM states, quad-X sign masks and accumulator sizing for the motor mixer.
package pid_mixer_defs;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  localparam logic [3:0] DEF_YAW_SIGN = 4'b0101;
  localparam logic [3:0] DEF_ROLL_SIGN = 4'b0011;
  localparam logic [3:0] DEF_PITCH_SIGN = 4'b1001;
  localparam logic ZERO = 1'b0;
  localparam int ACC_PAD = 3;
  function automatic int acc_width(input int bw);
    return bw + ACC_PAD;
  endfunction
endpackage

// File: rtl/mixer_term_sum.sv
// mixer_term_sum: signed add/shift/clamp of one motor rate; neg_i bits select subtraction of yaw/roll/pitch.
module mixer_term_sum import pid_mixer_defs::*; #(
  parameter int BIT_WIDTH = 16,
  parameter int DIVIDE_SHIFT = 1,
  parameter int unsigned RATE_MAX = 2**BIT_WIDTH-1
) (
  input  logic [BIT_WIDTH-1:0] bias_i,
  input  logic [BIT_WIDTH-1:0] throttle_i,
  input  logic [BIT_WIDTH-1:0] yaw_i,
  input  logic [BIT_WIDTH-1:0] roll_i,
  input  logic [BIT_WIDTH-1:0] pitch_i,
  input  logic [2:0]           neg_i,
  output logic [BIT_WIDTH-1:0] rate_o,
  output logic                 sat_o
);
  localparam int AW = acc_width(BIT_WIDTH);
  localparam logic signed [AW-1:0] RMAX = AW'(RATE_MAX);
  logic signed [AW-1:0] yaw_t, roll_t, pitch_t, sum;
  assign yaw_t = $signed({{ACC_PAD{yaw_i[BIT_WIDTH-1]}}, yaw_i}) >>> DIVIDE_SHIFT;
  assign roll_t = $signed({{ACC_PAD{roll_i[BIT_WIDTH-1]}}, roll_i}) >>> DIVIDE_SHIFT;
  assign pitch_t = $signed({{ACC_PAD{pitch_i[BIT_WIDTH-1]}}, pitch_i}) >>> DIVIDE_SHIFT;
  assign sum = $signed({{ACC_PAD{1'b0}}, bias_i}) + $signed({{ACC_PAD{1'b0}}, throttle_i})
             + (neg_i[0] ? -yaw_t : yaw_t)
             + (neg_i[1] ? -roll_t : roll_t)
             + (neg_i[2] ? -pitch_t : pitch_t);
  assign sat_o = (sum < 0) || (sum > RMAX);
  assign rate_o = sum < 0 ? '0 : sum > RMAX ? RMAX[BIT_WIDTH-1:0] : sum[BIT_WIDTH-1:0];
endmodule

// File: rtl/motor_mixer_seq.sv
// motor_mixer_seq: time-shared multi-motor rate mixer, one motor per cycle, all results published atomically.
module motor_mixer_seq import pid_mixer_defs::*; #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_MOTORS = 4,
  parameter int DIVIDE_SHIFT = 1,
  parameter logic [NUM_MOTORS-1:0] YAW_SIGN = DEF_YAW_SIGN,
  parameter logic [NUM_MOTORS-1:0] ROLL_SIGN = DEF_ROLL_SIGN,
  parameter logic [NUM_MOTORS-1:0] PITCH_SIGN = DEF_PITCH_SIGN,
  parameter int unsigned RATE_MAX = 2**BIT_WIDTH-1
) (
  input  logic                             sys_clk,
  input  logic                             rst,
  input  logic                             armed,
  input  logic                             start,
  input  logic [BIT_WIDTH-1:0]             bias,
  input  logic [BIT_WIDTH-1:0]             throttle_rate,
  input  logic [BIT_WIDTH-1:0]             yaw_rate,
  input  logic [BIT_WIDTH-1:0]             roll_rate,
  input  logic [BIT_WIDTH-1:0]             pitch_rate,
  output logic [NUM_MOTORS*BIT_WIDTH-1:0]  motor_rates,
  output logic [NUM_MOTORS-1:0]            motor_sat,
  output logic                             motor_valid,
  output logic                             busy,
  output logic                             overrun
);
  localparam int IW = $clog2(NUM_MOTORS);
  state_e state_q;
  logic [IW-1:0] idx_q;
  logic [BIT_WIDTH-1:0] bias_q, thr_q, yaw_q, roll_q, pitch_q;
  logic [NUM_MOTORS-1:0][BIT_WIDTH-1:0] shadow_q, rates_q;
  logic [NUM_MOTORS-1:0] shadow_sat_q, sat_q;
  logic valid_q, overrun_q;
  logic [BIT_WIDTH-1:0] rate_d;
  logic sat_d;
  mixer_term_sum #(
    .BIT_WIDTH(BIT_WIDTH),
    .DIVIDE_SHIFT(DIVIDE_SHIFT),
    .RATE_MAX(RATE_MAX)
  ) u_term (
    .bias_i(bias_q),
    .throttle_i(thr_q),
    .yaw_i(yaw_q),
    .roll_i(roll_q),
    .pitch_i(pitch_q),
    .neg_i({PITCH_SIGN[idx_q], ROLL_SIGN[idx_q], YAW_SIGN[idx_q]}),
    .rate_o(rate_d),
    .sat_o(sat_d)
  );
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      {bias_q, thr_q, yaw_q, roll_q, pitch_q} <= '0;
      shadow_q <= '0;
      shadow_sat_q <= '0;
      rates_q <= '0;
      sat_q <= '0;
      valid_q <= ZERO;
      overrun_q <= ZERO;
    end else begin
      valid_q <= ZERO;
      overrun_q <= armed && start && state_q != S_IDLE;
      if (!armed) begin
        state_q <= S_IDLE;
        rates_q <= '0;
        sat_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            {bias_q, thr_q, yaw_q, roll_q, pitch_q} <= {bias, throttle_rate, yaw_rate, roll_rate, pitch_rate};
            idx_q <= '0;
            state_q <= S_CALC;
          end
          S_CALC: begin
            shadow_q[idx_q] <= rate_d;
            shadow_sat_q[idx_q] <= sat_d;
            idx_q <= idx_q == IW'(NUM_MOTORS-1) ? '0 : idx_q + 1'b1;
            state_q <= idx_q == IW'(NUM_MOTORS-1) ? S_DONE : S_CALC;
          end
          S_DONE: begin
            rates_q <= shadow_q;
            sat_q <= shadow_sat_q;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign motor_rates = rates_q;
  assign motor_sat = sat_q;
  assign motor_valid = valid_q;
  assign busy = state_q != S_IDLE;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_motor_mixer_seq.sv
// tb_motor_mixer_seq: directed and random checks of the four-motor mixer against a real-arithmetic model.
module tb_motor_mixer_seq;
  localparam bit [3:0] YAW_M = 4'b0101;
  localparam bit [3:0] ROLL_M = 4'b0011;
  localparam bit [3:0] PITCH_M = 4'b1001;
  logic sys_clk = 0, rst = 1, armed = 0, start = 0;
  logic [15:0] bias = 0, throttle_rate = 0, yaw_rate = 0, roll_rate = 0, pitch_rate = 0;
  logic [63:0] motor_rates;
  logic [3:0] motor_sat;
  logic motor_valid, busy, overrun;
  int n_chk = 0, n_fail = 0;
  motor_mixer_seq dut (
    .sys_clk(sys_clk), .rst(rst), .armed(armed), .start(start), .bias(bias),
    .throttle_rate(throttle_rate), .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
    .motor_rates(motor_rates), .motor_sat(motor_sat), .motor_valid(motor_valid),
    .busy(busy), .overrun(overrun)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic int half_floor(input logic [15:0] v);
    return int'($floor(real'($signed(v)) / 2.0));
  endfunction
  task automatic model(input logic [15:0] b, t, y, r, p, output logic [63:0] er, output logic [3:0] es);
    er = '0;
    es = '0;
    for (int i = 0; i < 4; i++) begin
      int s;
      s = int'(b) + int'(t);
      s += YAW_M[i] ? -half_floor(y) : half_floor(y);
      s += ROLL_M[i] ? -half_floor(r) : half_floor(r);
      s += PITCH_M[i] ? -half_floor(p) : half_floor(p);
      es[i] = (s < 0) || (s > 65535);
      er[i*16 +: 16] = s < 0 ? 16'd0 : s > 65535 ? 16'hFFFF : 16'(s);
    end
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!motor_valid && n < 20);
    if (!motor_valid) chk("valid_timeout", {63'd0, motor_valid}, 64'd1);
  endtask
  task automatic drive_start(input logic [15:0] b, t, y, r, p);
    @(negedge sys_clk);
    {bias, throttle_rate, yaw_rate, roll_rate, pitch_rate} = {b, t, y, r, p};
    start = 1;
    @(negedge sys_clk);
    start = 0;
  endtask
  task automatic run_set(input string tag, input logic [15:0] b, t, y, r, p);
    logic [63:0] er;
    logic [3:0] es;
    int n;
    model(b, t, y, r, p, er, es);
    drive_start(b, t, y, r, p);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_valid(n);
    chk({tag, "_latency"}, 64'(n), 64'd5);
    chk({tag, "_rates"}, motor_rates, er);
    chk({tag, "_sat"}, {60'd0, motor_sat}, {60'd0, es});
    @(negedge sys_clk);
    chk({tag, "_pulse"}, {63'd0, motor_valid}, 64'd0);
  endtask
  initial begin
    logic [63:0] er;
    logic [3:0] es;
    int n, nv;
    repeat (3) @(negedge sys_clk);
    chk("rst_rates", motor_rates, 64'd0);
    chk("rst_flags", {60'd0, motor_sat, motor_valid, busy, overrun}, 64'd0);
    rst = 0;
    @(negedge sys_clk);
    start = 1;
    throttle_rate = 16'd500;
    @(negedge sys_clk);
    start = 0;
    chk("disarmed_start_busy", {62'd0, busy, overrun}, 64'd0);
    armed = 1;
    run_set("yaw", 16'd0, 16'd1000, 16'd200, 16'd0, 16'd0);
    chk("yaw_literal", motor_rates, {16'd1100, 16'd900, 16'd1100, 16'd900});
    run_set("floor", 16'd0, 16'd10, 16'd0, 16'hFFFD, 16'd0);
    chk("floor_literal", motor_rates, {16'd8, 16'd8, 16'd12, 16'd12});
    run_set("hi_clamp", 16'd0, 16'd65535, 16'd200, 16'd0, 16'd0);
    chk("hi_clamp_sat", {60'd0, motor_sat}, 64'hA);
    run_set("lo_clamp", 16'd0, 16'd50, 16'd0, 16'd0, 16'hFE70);
    chk("lo_clamp_sat", {60'd0, motor_sat}, 64'h6);
    for (int k = 0; k < 20; k++)
      run_set("rand", 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    model(16'd7, 16'd3000, 16'd100, 16'hFF38, 16'd60, er, es);
    drive_start(16'd7, 16'd3000, 16'd100, 16'hFF38, 16'd60);
    @(negedge sys_clk);
    {bias, throttle_rate, yaw_rate, roll_rate, pitch_rate} = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    start = 1;
    @(negedge sys_clk);
    start = 0;
    chk("overrun_pulse", {63'd0, overrun}, 64'd1);
    @(negedge sys_clk);
    chk("overrun_clear", {63'd0, overrun}, 64'd0);
    wait_valid(n);
    chk("overrun_latency", 64'(n), 64'd2);
    chk("overrun_rates", motor_rates, er);
    chk("overrun_sat", {60'd0, motor_sat}, {60'd0, es});
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      nv += int'(motor_valid);
    end
    chk("overrun_single_valid", 64'(nv), 64'd0);
    drive_start(16'd0, 16'd2000, 16'd0, 16'd0, 16'd0);
    @(negedge sys_clk);
    armed = 0;
    @(negedge sys_clk);
    chk("disarm_rates", motor_rates, 64'd0);
    chk("disarm_flags", {61'd0, motor_sat == 4'd0, motor_valid, busy}, 64'h4);
    armed = 1;
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      nv += int'(motor_valid);
    end
    chk("disarm_no_valid", 64'(nv), 64'd0);
    run_set("pre_rst", 16'd100, 16'd4000, 16'd0, 16'd0, 16'd0);
    drive_start(16'd0, 16'd123, 16'd0, 16'd0, 16'd0);
    @(negedge sys_clk);
    rst = 1;
    @(negedge sys_clk);
    rst = 0;
    chk("midrst_rates", motor_rates, 64'd0);
    chk("midrst_flags", {60'd0, motor_sat, motor_valid, busy, overrun}, 64'd0);
    run_set("post_rst", 16'd20, 16'd800, 16'hFFF0, 16'd32, 16'hFF00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
